// File: rtl/word_tok_pkg.sv
// Shared constants and helpers for the word tokenizer: token codes, FSM state
// encoding, ASCII constants and the case-fold / character-range helpers.
package word_tok_pkg;

  localparam logic [1:0] TOK_OTHER = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_B     = 4'd1;
  localparam logic [3:0] ST_BE    = 4'd2;
  localparam logic [3:0] ST_BEG   = 4'd3;
  localparam logic [3:0] ST_BEGI  = 4'd4;
  localparam logic [3:0] ST_BEGIN = 4'd5;
  localparam logic [3:0] ST_E     = 4'd6;
  localparam logic [3:0] ST_EN    = 4'd7;
  localparam logic [3:0] ST_END   = 4'd8;
  localparam logic [3:0] ST_OTHER = 4'd9;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5a);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7a);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return is_upper(c) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/word_tokenizer_char_class.sv
// Combinational character classifier: folds case and flags separators.
// Optional feature macro: WORD_TOK_PUNCT_EN (non-alphanumerics also separate).
module char_class
  import word_tok_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [7:0] o_fold,
  output logic       o_is_sep
);

  assign o_fold = fold_case(i_char);

`ifdef WORD_TOK_PUNCT_EN
  assign o_is_sep = !is_lower(o_fold) && !is_digit(i_char);
`else
  assign o_is_sep = (i_char == CH_SPACE);
`endif

endmodule

// File: rtl/word_tokenizer.sv
// Splits an ASCII stream into words and emits one registered BEGIN/END/OTHER
// token per word. Optional feature macro: WORD_TOK_PUNCT_EN (see char_class).
module word_tokenizer
  import word_tok_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  input  logic             flush,
  output logic             tok_valid,
  output logic [1:0]       tok_code,
  output logic [LEN_W-1:0] word_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_tok_valid;
  logic [1:0]       r_tok_code;
  logic [LEN_W-1:0] r_word_len;

  logic [7:0]       w_fold;
  logic             w_is_sep;
  logic [3:0]       w_char_state;
  logic [LEN_W-1:0] w_char_len;
  logic [3:0]       w_next_state;
  logic [LEN_W-1:0] w_next_len;
  logic             w_emit;
  logic [1:0]       w_emit_code;
  logic [LEN_W-1:0] w_emit_len;

  char_class u_char_class (
    .i_char   (in),
    .o_fold   (w_fold),
    .o_is_sep (w_is_sep)
  );

  // Successor state when a word character arrives.
  function automatic logic [3:0] word_step(input logic [3:0] s, input logic [7:0] c);
    case (s)
      ST_IDLE: word_step = (c == CH_B) ? ST_B : ((c == CH_E) ? ST_E : ST_OTHER);
      ST_B:    word_step = (c == CH_E) ? ST_BE   : ST_OTHER;
      ST_BE:   word_step = (c == CH_G) ? ST_BEG  : ST_OTHER;
      ST_BEG:  word_step = (c == CH_I) ? ST_BEGI : ST_OTHER;
      ST_BEGI: word_step = (c == CH_N) ? ST_BEGIN : ST_OTHER;
      ST_E:    word_step = (c == CH_N) ? ST_EN  : ST_OTHER;
      ST_EN:   word_step = (c == CH_D) ? ST_END : ST_OTHER;
      default: word_step = ST_OTHER;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input logic [3:0] s);
    case (s)
      ST_BEGIN: code_of = TOK_BEGIN;
      ST_END:   code_of = TOK_END;
      default:  code_of = TOK_OTHER;
    endcase
  endfunction

  // Character step first, then flush terminates whatever word that leaves pending.
  always_comb begin
    w_char_state = r_state;
    w_char_len   = r_len;
    w_next_state = r_state;
    w_next_len   = r_len;
    w_emit       = 1'b0;
    w_emit_code  = TOK_OTHER;
    w_emit_len   = r_len;
    if (in_valid) begin
      if (w_is_sep) begin
        w_char_state = ST_IDLE;
        w_char_len   = {LEN_W{1'b0}};
        w_emit       = (r_state != ST_IDLE);
        w_emit_code  = code_of(r_state);
        w_emit_len   = r_len;
      end else begin
        w_char_state = word_step(r_state, w_fold);
        w_char_len   = (r_len == LEN_MAX) ? r_len : (r_len + LEN_ONE);
      end
    end else begin
      w_char_state = r_state;
    end
    w_next_state = w_char_state;
    w_next_len   = w_char_len;
    if (flush && (w_char_state != ST_IDLE)) begin
      w_emit       = 1'b1;
      w_emit_code  = code_of(w_char_state);
      w_emit_len   = w_char_len;
      w_next_state = ST_IDLE;
      w_next_len   = {LEN_W{1'b0}};
    end else begin
      w_next_state = w_char_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len       <= {LEN_W{1'b0}};
      r_tok_valid <= 1'b0;
      r_tok_code  <= TOK_OTHER;
      r_word_len  <= {LEN_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_len       <= w_next_len;
      r_tok_valid <= w_emit;
      if (w_emit) begin
        r_tok_code <= w_emit_code;
        r_word_len <= w_emit_len;
      end
    end
  end

  assign tok_valid = r_tok_valid;
  assign tok_code  = r_tok_code;
  assign word_len  = r_word_len;

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: a word-buffer reference model checked
// every cycle, plus hand-computed token lists per directed scenario.
module tb_word_tokenizer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ch  = 8'd0;
  logic       vld = 1'b0;
  logic       fl  = 1'b0;

  logic       tok_valid_a, tok_valid_b;
  logic [1:0] tok_code_a, tok_code_b;
  logic [5:0] len_a;
  logic [2:0] len_b;

  int nchecks = 0;
  int nerrors = 0;
  bit cmp_en  = 1'b0;

  // Reference model: pending word as folded bytes, plus the expected outputs.
  byte unsigned wq[$];
  logic         exp_valid = 1'b0;
  logic [1:0]   exp_code  = 2'd0;
  int           exp_len   = 0;

  int log_a[$];
  int log_b[$];
  int exp_log[$];

  always #5 clk = ~clk;

  word_tokenizer #(.LEN_W(6)) dut_a (
    .clk(clk), .reset(rst), .in(ch), .in_valid(vld), .flush(fl),
    .tok_valid(tok_valid_a), .tok_code(tok_code_a), .word_len(len_a)
  );

  word_tokenizer #(.LEN_W(3)) dut_b (
    .clk(clk), .reset(rst), .in(ch), .in_valid(vld), .flush(fl),
    .tok_valid(tok_valid_b), .tok_code(tok_code_b), .word_len(len_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic byte unsigned mfold(input byte unsigned c);
    return (c >= 8'd65 && c <= 8'd90) ? c + 8'd32 : c;
  endfunction

  function automatic bit msep(input byte unsigned c);
`ifdef WORD_TOK_PUNCT_EN
    byte unsigned f = mfold(c);
    return !((f >= 8'd97 && f <= 8'd122) || (c >= 8'd48 && c <= 8'd57));
`else
    return c == 8'd32;
`endif
  endfunction

  function automatic logic [1:0] classify();
    if (wq.size() == 5 && wq[0] == 8'h62 && wq[1] == 8'h65 && wq[2] == 8'h67 &&
        wq[3] == 8'h69 && wq[4] == 8'h6e) return 2'd1;
    if (wq.size() == 3 && wq[0] == 8'h65 && wq[1] == 8'h6e && wq[2] == 8'h64) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_emit();
    exp_valid = 1'b1;
    exp_code  = classify();
    exp_len   = wq.size();
    wq.delete();
  endtask

  task automatic model_step();
    if (!rst) begin
      wq.delete();
      exp_valid = 1'b0;
      exp_code  = 2'd0;
      exp_len   = 0;
    end else begin
      exp_valid = 1'b0;
      if (vld) begin
        if (msep(ch)) begin
          if (wq.size() > 0) model_emit();
        end else begin
          wq.push_back(mfold(ch));
        end
      end
      if (fl && wq.size() > 0) model_emit();
    end
  endtask

  // One cycle: apply inputs, let the edge happen, return at the falling edge.
  task automatic send(input logic [7:0] c, input logic v, input logic f);
    ch  = c;
    vld = v;
    fl  = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_log(input string name, input bit use_b);
    idle(2);
    if (use_b) begin
      check({name, "_count"}, log_b.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < log_b.size(); i++)
        check({name, "_tok"}, log_b[i], exp_log[i]);
    end else begin
      check({name, "_count"}, log_a.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < log_a.size(); i++)
        check({name, "_tok"}, log_a[i], exp_log[i]);
    end
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tok_valid_a", tok_valid_a, exp_valid);
      check("tok_code_a",  tok_code_a,  exp_code);
      check("word_len_a",  len_a, (exp_len > 63) ? 63 : exp_len);
      check("tok_valid_b", tok_valid_b, exp_valid);
      check("tok_code_b",  tok_code_b,  exp_code);
      check("word_len_b",  len_b, (exp_len > 7) ? 7 : exp_len);
      if (tok_valid_a === 1'b1) log_a.push_back(int'(tok_code_a) * 100 + int'(len_a));
      if (tok_valid_b === 1'b1) log_b.push_back(int'(tok_code_b) * 100 + int'(len_b));
    end
  end

  initial begin
    string s;
    rst = 1'b0;
    idle(2);
    check("reset_valid", tok_valid_a, 1'b0);
    check("reset_code",  tok_code_a,  2'd0);
    check("reset_len",   len_a,       6'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Basic words, token pulse right after each space.
    s = "begin end end begin ";
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b1, 1'b0);
      if (s[i] == 8'd32) check("pulse_after_space", tok_valid_a, 1'b1);
    end
    exp_log = '{105, 203, 203, 105};
    expect_log("basic", 1'b0);
    clear_logs();

    send_str("BeGiN EnD ");
    exp_log = '{105, 203};
    expect_log("case_fold", 1'b0);
    clear_logs();

    send_str("beg ending begins x ");
    exp_log = '{3, 6, 6, 1};
    expect_log("near_miss", 1'b0);
    clear_logs();

    send_str("a b c ");
    exp_log = '{1, 1, 1};
    expect_log("back_to_back", 1'b0);
    clear_logs();

    // Flush without a character, then a redundant flush.
    send_str("  end");
    check("no_tok_before_flush", tok_valid_a, 1'b0);
    send(8'd0, 1'b0, 1'b1);
    check("flush_latency", tok_valid_a, 1'b1);
    send(8'd0, 1'b0, 1'b1);
    check("second_flush_silent", tok_valid_a, 1'b0);
    exp_log = '{203};
    expect_log("flush", 1'b0);
    clear_logs();

    // Reset mid-word drops the partial "begi".
    send_str("begi");
    rst = 1'b0;
    send(8'd0, 1'b0, 1'b0);
    check("midreset_valid", tok_valid_a, 1'b0);
    check("midreset_code",  tok_code_a,  2'd0);
    check("midreset_len",   len_a,       6'd0);
    rst = 1'b1;
    send_str("n ");
    exp_log = '{1};
    expect_log("reset_drop", 1'b0);
    clear_logs();

    // Stall mid-word, flush with a char, flush with a separator.
    send_str("be");
    idle(3);
    send_str("gin ");
    send_str("en");
    send(8'h64, 1'b1, 1'b1);
    send_str("x");
    send(8'h20, 1'b1, 1'b1);
    exp_log = '{105, 203, 1};
    expect_log("stall_flush", 1'b0);
    clear_logs();

    send_str("abcdefghij ");
    exp_log = '{10};
    expect_log("len10_a", 1'b0);
    exp_log = '{7};
    expect_log("len10_b", 1'b1);
    clear_logs();

    for (int i = 0; i < 70; i++) send(8'h61, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    exp_log = '{63};
    expect_log("sat_a", 1'b0);
    exp_log = '{7};
    expect_log("sat_b", 1'b1);
    clear_logs();

    send_str("begin;end.");
    send(8'd0, 1'b0, 1'b1);
    send_str("begin; ");
`ifdef WORD_TOK_PUNCT_EN
    exp_log = '{105, 203, 105};
`else
    exp_log = '{10, 6};
`endif
    expect_log("punct", 1'b0);
    clear_logs();

    idle(2);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/word_tokenizer.md
# word_tokenizer

Front-end lexer for the P1 block checker. Consumes a stream of ASCII characters, one per accepted cycle, and splits it into separator-delimited words. Classifies each completed word as `begin`, `end` or other, case-insensitively. Emits one registered token per word; the downstream bracket-depth checker consumes these tokens instead of raw characters.

## Interface
Parameters:
- `LEN_W`, default 6: width of the word-length counter (saturating).

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-low (0 = reset).
- `in`, in, 8: ASCII character.
- `in_valid`, in, 1: `in` is accepted on every clock edge where this is high.
- `flush`, in, 1: terminates the current word at this edge, as if a separator followed.
- `tok_valid`, out, 1: one-cycle pulse; the token fields are valid.
- `tok_code`, out, 2: 0 = OTHER, 1 = BEGIN, 2 = END; 3 is never driven.
- `word_len`, out, LEN_W: character count of the emitted word, saturating at 2^LEN_W−1.

## Operation
- Separator is 0x20 (space). All other bytes are word characters, unless `WORD_TOK_PUNCT_EN` is set (see Configuration).
- Case fold: bytes 0x41–0x5A are ORed with 0x20 before matching. No other bytes are altered.
- FSM states: IDLE, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER.
- IDLE (between words):
  - 'b' → B; 'e' → E; any other word char → OTHER.
  - Separator → IDLE, no token.
- Match chain, one state per matched letter: B→BE→BEG→BEGI→BEGIN on "egin"; E→EN→END on "nd".
- Any mismatching word char from a match state → OTHER. A word char in BEGIN or END (e.g. "begins", "ending") → OTHER.
- OTHER holds on word chars.
- Separator accepted in any non-IDLE state → emit token, go to IDLE:
  - from BEGIN: BEGIN token.
  - from END: END token.
  - from any other non-IDLE state (including partial prefixes such as "beg"): OTHER token.
- `flush`:
  - If `in_valid` is also high, `in` is processed first. The resulting word, if non-empty, is then terminated.
  - A separator together with `flush` produces at most one token.
  - Flush in IDLE with no pending word → no token.
- `word_len`:
  - Counter cleared on entering IDLE.
  - Incremented per accepted word char, saturating.
  - The emitted value includes the char accepted in the terminating cycle, when that char is a word char under flush.
- `in_valid` low and `flush` low: state and counter hold.

## Timing
- Reset (`reset`=0 at an edge): state = IDLE, `tok_valid`=0, `tok_code`=0, `word_len`=0. Any partial word is discarded and no token is emitted, including when reset arrives mid-word.
- Latency: the token is registered. `tok_valid` is high in the cycle after the edge that accepted the terminating separator or flush.
- `tok_code` and `word_len` hold their last values while `tok_valid`=0.
- Throughput: one char per cycle. Back-to-back single-char words ("a b c …") produce a token every second cycle, with no stalls.
- No backpressure: the consumer must accept every `tok_valid` pulse.
- Saturation: a word longer than 2^LEN_W−1 chars still classifies correctly (OTHER) and reports `word_len` = all-ones.

## Configuration
- `WORD_TOK_PUNCT_EN` defined: every byte that is not a letter (after folding) and not an ASCII digit is also a separator, so "begin;end." yields BEGIN, END.
- Undefined: only 0x20 separates, and punctuation is a word char ("begin;" → OTHER, length 6).

## Structure
- Shared package `word_tok_pkg`: token code constants (TOK_OTHER, TOK_BEGIN, TOK_END), the FSM state encoding, the ASCII constants (space, 'b', 'e', 'g', 'i', 'n', 'd'), and the case-fold/letter-range helper.
- One natural sub-module: `char_class`. It is combinational, takes `in`, and returns the folded char plus an is_separator flag. It is the only place `WORD_TOK_PUNCT_EN` is tested.
- FSM, counter and output registers live in `word_tokenizer`.

## Test plan
- "begin end end begin " at one char per cycle → tokens BEGIN/5, END/3, END/3, BEGIN/5. Each `tok_valid` pulse occurs one cycle after its space.
- "BeGiN EnD " → BEGIN/5, END/3 (case fold).
- "beg ending begins x " → OTHER/3, OTHER/6, OTHER/6, OTHER/1.
- "  end" then `flush` with `in_valid`=0 → no tokens for the leading spaces, then END/3 one cycle after the flush. A second flush → no token.
- Reset asserted after "begi", then "n " → a single OTHER/1 token, proving the partial word was dropped.
- With LEN_W=3 and "abcdefghij " → OTHER/7. With `WORD_TOK_PUNCT_EN`, "begin;end." plus flush → BEGIN/5, END/3.
